// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and types for the 7-segment scan capture path.
//   Glyph codes (5-bit), active-low cathode patterns {g,f,e,d,c,b,a},
//   active-low one-hot anode patterns, and the registered bus sample type.
package seg_pkg;

  localparam int unsigned GLYPH_W    = 5;
  localparam int unsigned AN_W       = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned IDX_W      = 2;
  localparam int unsigned DWELL_W    = 8;

  // Glyph codes; decimal digits map to 5'h00..5'h09
  localparam logic [GLYPH_W-1:0] GLYPH_US  = 5'h10;
  localparam logic [GLYPH_W-1:0] GLYPH_A   = 5'h11;
  localparam logic [GLYPH_W-1:0] GLYPH_P   = 5'h12;
  localparam logic [GLYPH_W-1:0] GLYPH_BAD = 5'h1F;

  // Active-low cathode patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_0   = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1   = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2   = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3   = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4   = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5   = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6   = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7   = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8   = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9   = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_US  = 7'b1110111;
  localparam logic [SEG_W-1:0] SEG_A   = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_P   = 7'b0001100;
  localparam logic [SEG_W-1:0] SEG_OFF = 7'b1111111;

  // Active-low one-hot anode enables; digit 0 is the rightmost
  localparam logic [AN_W-1:0] AN_D0    = 4'b1110;
  localparam logic [AN_W-1:0] AN_D1    = 4'b1101;
  localparam logic [AN_W-1:0] AN_D2    = 4'b1011;
  localparam logic [AN_W-1:0] AN_D3    = 4'b0111;
  localparam logic [AN_W-1:0] AN_BLANK = 4'b1111;

  typedef struct packed {
    logic [AN_W-1:0]  an;
    logic [SEG_W-1:0] seg;
  } bus_sample_t;

  // Idle bus: all anodes off, all cathodes dark
  localparam bus_sample_t IDLE_SAMPLE = '{an: AN_BLANK, seg: SEG_OFF};

endpackage

// File: rtl/seg_glyph_decode.sv
// seg_glyph_decode: combinational cathode pattern -> glyph code lookup.
//   seg_i   : active-low cathodes {g,f,e,d,c,b,a}
//   glyph_o : 5-bit glyph code, GLYPH_BAD for any undefined pattern
module seg_glyph_decode
  import seg_pkg::*;
(
  input  logic [SEG_W-1:0]   seg_i,
  output logic [GLYPH_W-1:0] glyph_o
);

  always_comb begin
    glyph_o = GLYPH_BAD;
    case (seg_i)
      SEG_0:   glyph_o = 5'h00;
      SEG_1:   glyph_o = 5'h01;
      SEG_2:   glyph_o = 5'h02;
      SEG_3:   glyph_o = 5'h03;
      SEG_4:   glyph_o = 5'h04;
      SEG_5:   glyph_o = 5'h05;
      SEG_6:   glyph_o = 5'h06;
      SEG_7:   glyph_o = 5'h07;
      SEG_8:   glyph_o = 5'h08;
      SEG_9:   glyph_o = 5'h09;
      SEG_US:  glyph_o = GLYPH_US;
      SEG_A:   glyph_o = GLYPH_A;
      SEG_P:   glyph_o = GLYPH_P;
      default: glyph_o = GLYPH_BAD;
    endcase
  end

endmodule

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: samples a multiplexed 4-digit anode/cathode bus, decodes
// each settled digit to a glyph code and reassembles full 0..3 scans.
//   CLK, rst_n   : clock, asynchronous active-low reset
//   an, seg      : active-low anode one-hot and cathodes {g,f,e,d,c,b,a}
//   clr_err      : synchronous clear of sticky glyph_err
//   digits       : {d3,d2,d1,d0} glyph codes, updated with frame_valid
//   frame_valid  : one-cycle pulse per completed in-order scan
//   scan_err     : one-cycle pulse on out-of-order or illegal anode pattern
//   glyph_err    : sticky, an undefined cathode pattern was captured
//   scan_stalled : level, no legal capture for TIMEOUT_CYCLES clocks
// Optional feature macro: SCAN_TIMEOUT_EN (stall timeout; else scan_stalled = 0).
module seg_scan_capture
  import seg_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 1
`ifdef SCAN_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 65535
`endif
) (
  input  logic                          CLK,
  input  logic                          rst_n,
  input  logic [AN_W-1:0]               an,
  input  logic [SEG_W-1:0]              seg,
  input  logic                          clr_err,
  output logic [NUM_DIGITS*GLYPH_W-1:0] digits,
  output logic                          frame_valid,
  output logic                          scan_err,
  output logic                          glyph_err,
  output logic                          scan_stalled
);

  localparam logic [DWELL_W-1:0] SETTLE = DWELL_W'(SETTLE_CYCLES);

  bus_sample_t                              samp_q, prev_q;
  logic [DWELL_W-1:0]                       dwell_q, dwell_d;
  logic                                     captured_q, captured_d, captured_hold;
  logic                                     capture;
  logic [IDX_W-1:0]                         next_idx_q, next_idx_d;
  logic [NUM_DIGITS-1:0][GLYPH_W-1:0]       shadow_q, shadow_d;
  logic [NUM_DIGITS*GLYPH_W-1:0]            digits_q, digits_d;
  logic                                     frame_valid_q, frame_valid_d;
  logic                                     scan_err_q, scan_err_d;
  logic                                     glyph_err_q, glyph_err_d;
  logic [GLYPH_W-1:0]                       glyph;
  logic                                     an_legal, an_blank;
  logic [IDX_W-1:0]                         an_idx;

  seg_glyph_decode u_decode (
    .seg_i   (samp_q.seg),
    .glyph_o (glyph)
  );

  // Dwell tracking: the count covers the current sample; one capture per dwell
  always_comb begin
    dwell_d       = DWELL_W'(1);
    captured_hold = 1'b0;
    if (samp_q == prev_q) begin
      dwell_d       = (dwell_q >= SETTLE) ? SETTLE : dwell_q + DWELL_W'(1);
      captured_hold = captured_q;
    end
    capture    = (dwell_d == SETTLE) && !captured_hold;
    captured_d = captured_hold | capture;
  end

  // Anode classification
  always_comb begin
    an_legal = 1'b0;
    an_blank = 1'b0;
    an_idx   = '0;
    case (samp_q.an)
      AN_D0:    begin an_legal = 1'b1; an_idx = 2'd0; end
      AN_D1:    begin an_legal = 1'b1; an_idx = 2'd1; end
      AN_D2:    begin an_legal = 1'b1; an_idx = 2'd2; end
      AN_D3:    begin an_legal = 1'b1; an_idx = 2'd3; end
      AN_BLANK: an_blank = 1'b1;
      default:  ;
    endcase
  end

`ifdef SCAN_TIMEOUT_EN
  localparam int unsigned     TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            stalled_q, stalled_d;
`endif

  // Sequencer next-state: shadow fill, publish on in-order digit 3
  always_comb begin
    next_idx_d    = next_idx_q;
    shadow_d      = shadow_q;
    digits_d      = digits_q;
    frame_valid_d = 1'b0;
    scan_err_d    = 1'b0;
    glyph_err_d   = glyph_err_q & ~clr_err;
    if (capture && !an_blank) begin
      if (!an_legal) begin
        scan_err_d = 1'b1;
        next_idx_d = '0;
      end else begin
        if (glyph == GLYPH_BAD) glyph_err_d = 1'b1;
        if (an_idx == next_idx_q) begin
          shadow_d[an_idx] = glyph;
          next_idx_d       = an_idx + IDX_W'(1);
          if (an_idx == IDX_W'(3)) begin
            digits_d      = {glyph, shadow_q[2], shadow_q[1], shadow_q[0]};
            frame_valid_d = 1'b1;
          end
        end else if (an_idx == '0) begin
          // Digit 0 out of turn starts a fresh scan
          scan_err_d  = 1'b1;
          shadow_d[0] = glyph;
          next_idx_d  = IDX_W'(1);
        end else begin
          scan_err_d = 1'b1;
          next_idx_d = '0;
        end
      end
    end
`ifdef SCAN_TIMEOUT_EN
    to_cnt_d  = to_cnt_q;
    stalled_d = stalled_q;
    if (capture && an_legal) begin
      to_cnt_d  = '0;
      stalled_d = 1'b0;
    end else begin
      if (to_cnt_q != TO_LIMIT) to_cnt_d = to_cnt_q + TO_W'(1);
      if (to_cnt_d == TO_LIMIT) begin
        stalled_d  = 1'b1;
        next_idx_d = '0;
      end
    end
`endif
  end

  // State and output registers
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      samp_q        <= IDLE_SAMPLE;
      prev_q        <= IDLE_SAMPLE;
      dwell_q       <= '0;
      captured_q    <= 1'b0;
      next_idx_q    <= '0;
      shadow_q      <= '0;
      digits_q      <= '0;
      frame_valid_q <= 1'b0;
      scan_err_q    <= 1'b0;
      glyph_err_q   <= 1'b0;
    end else begin
      samp_q        <= '{an: an, seg: seg};
      prev_q        <= samp_q;
      dwell_q       <= dwell_d;
      captured_q    <= captured_d;
      next_idx_q    <= next_idx_d;
      shadow_q      <= shadow_d;
      digits_q      <= digits_d;
      frame_valid_q <= frame_valid_d;
      scan_err_q    <= scan_err_d;
      glyph_err_q   <= glyph_err_d;
    end
  end

`ifdef SCAN_TIMEOUT_EN
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q  <= '0;
      stalled_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      stalled_q <= stalled_d;
    end
  end

  assign scan_stalled = stalled_q;
`else
  assign scan_stalled = 1'b0;
`endif

  assign digits      = digits_q;
  assign frame_valid = frame_valid_q;
  assign scan_err    = scan_err_q;
  assign glyph_err   = glyph_err_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// tb_seg_scan_capture: directed table-driven bench for seg_scan_capture.
//   Instance A: SETTLE_CYCLES = 1 (TIMEOUT_CYCLES = 16 when SCAN_TIMEOUT_EN).
//   Instance B: SETTLE_CYCLES = 3 for glitch filtering.
`timescale 1ns/1ps
module tb_seg_scan_capture;
  import seg_pkg::*;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic [3:0]  an_a, an_b;
  logic [6:0]  seg_a, seg_b;
  logic        clr_a, clr_b;
  logic [19:0] dig_a, dig_b;
  logic        fv_a, fv_b, err_a, err_b, gerr_a, gerr_b, stall_a, stall_b;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  seg_scan_capture #(
    .SETTLE_CYCLES(1)
`ifdef SCAN_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(16)
`endif
  ) u_a (
    .CLK(CLK), .rst_n(rst_n), .an(an_a), .seg(seg_a), .clr_err(clr_a),
    .digits(dig_a), .frame_valid(fv_a), .scan_err(err_a),
    .glyph_err(gerr_a), .scan_stalled(stall_a)
  );

  seg_scan_capture #(
    .SETTLE_CYCLES(3)
  ) u_b (
    .CLK(CLK), .rst_n(rst_n), .an(an_b), .seg(seg_b), .clr_err(clr_b),
    .digits(dig_b), .frame_valid(fv_b), .scan_err(err_b),
    .glyph_err(gerr_b), .scan_stalled(stall_b)
  );

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        clr;
    logic        fv;
    logic        err;
    logic        gerr;
    logic [19:0] dig;
  } vec_t;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    int         n;
  } bvec_t;

  localparam logic [19:0] DIG_1234 = 20'h20C41;  // {04,03,02,01}
  localparam logic [19:0] DIG_US_P = 20'h19650;  // {03,05,12,10}
  localparam logic [19:0] DIG_BAD2 = 20'h27C41;  // {04,1F,02,01}
  localparam logic [19:0] DIG_B    = 20'h20CE1;  // {04,03,07,01}
  localparam logic [6:0]  SEG_JUNK = 7'b0110110; // a,d,g lit: no glyph
  localparam logic [3:0]  AN_TWO   = 4'b1100;    // two anodes on

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step_a(input logic [3:0] a, input logic [6:0] s, input logic c);
    an_a  = a;
    seg_a = s;
    clr_a = c;
    @(posedge CLK);
    #1;
  endtask

  function automatic vec_t mk(input logic [3:0] a, input logic [6:0] s, input logic c,
                              input logic f, input logic e, input logic g,
                              input logic [19:0] d);
    vec_t v;
    v.an = a; v.seg = s; v.clr = c; v.fv = f; v.err = e; v.gerr = g; v.dig = d;
    return v;
  endfunction

  vec_t  vecs[$];
  bvec_t bseq[$];

  initial begin
    int fv_cnt;
    int err_cnt;
    logic [19:0] last_b;

    rst_n = 1'b0;
    an_a = AN_BLANK; seg_a = SEG_OFF; clr_a = 1'b0;
    an_b = AN_BLANK; seg_b = SEG_OFF; clr_b = 1'b0;

    // Expected outputs are those seen after the step's clock edge, i.e. the
    // result of capturing the previous step's inputs.
    vecs.push_back(mk(AN_D0, SEG_1,    0, 0, 0, 0, 20'h0));
    vecs.push_back(mk(AN_D1, SEG_2,    0, 0, 0, 0, 20'h0));
    vecs.push_back(mk(AN_D2, SEG_3,    0, 0, 0, 0, 20'h0));
    vecs.push_back(mk(AN_D3, SEG_4,    0, 0, 0, 0, 20'h0));
    vecs.push_back(mk(AN_D0, SEG_1,    0, 1, 0, 0, DIG_1234));
    vecs.push_back(mk(AN_D1, SEG_2,    0, 0, 0, 0, DIG_1234));
    vecs.push_back(mk(AN_D2, SEG_3,    0, 0, 0, 0, DIG_1234));
    vecs.push_back(mk(AN_D3, SEG_4,    0, 0, 0, 0, DIG_1234));
    vecs.push_back(mk(AN_D0, SEG_US,   0, 1, 0, 0, DIG_1234));
    vecs.push_back(mk(AN_D1, SEG_P,    0, 0, 0, 0, DIG_1234));
    vecs.push_back(mk(AN_D2, SEG_5,    0, 0, 0, 0, DIG_1234));
    vecs.push_back(mk(AN_D3, SEG_3,    0, 0, 0, 0, DIG_1234));
    vecs.push_back(mk(AN_D0, SEG_1,    0, 1, 0, 0, DIG_US_P));
    vecs.push_back(mk(AN_D1, SEG_2,    0, 0, 0, 0, DIG_US_P));
    vecs.push_back(mk(AN_D3, SEG_4,    0, 0, 0, 0, DIG_US_P));
    vecs.push_back(mk(AN_D2, SEG_3,    0, 0, 1, 0, DIG_US_P));
    vecs.push_back(mk(AN_D0, SEG_1,    0, 0, 1, 0, DIG_US_P));
    vecs.push_back(mk(AN_D1, SEG_2,    0, 0, 0, 0, DIG_US_P));
    vecs.push_back(mk(AN_D2, SEG_3,    0, 0, 0, 0, DIG_US_P));
    vecs.push_back(mk(AN_D3, SEG_4,    0, 0, 0, 0, DIG_US_P));
    vecs.push_back(mk(AN_BLANK, SEG_OFF, 0, 1, 0, 0, DIG_1234));
    vecs.push_back(mk(AN_BLANK, SEG_OFF, 0, 0, 0, 0, DIG_1234));
    vecs.push_back(mk(AN_TWO, SEG_1,   0, 0, 0, 0, DIG_1234));
    vecs.push_back(mk(AN_D0, SEG_1,    0, 0, 1, 0, DIG_1234));
    vecs.push_back(mk(AN_D1, SEG_2,    0, 0, 0, 0, DIG_1234));
    vecs.push_back(mk(AN_D2, SEG_JUNK, 0, 0, 0, 0, DIG_1234));
    vecs.push_back(mk(AN_D3, SEG_4,    0, 0, 0, 1, DIG_1234));
    vecs.push_back(mk(AN_D0, SEG_1,    0, 1, 0, 1, DIG_BAD2));
    vecs.push_back(mk(AN_BLANK, SEG_OFF, 0, 0, 0, 1, DIG_BAD2));
    vecs.push_back(mk(AN_BLANK, SEG_OFF, 1, 0, 0, 0, DIG_BAD2));
    vecs.push_back(mk(AN_D2, SEG_JUNK, 0, 0, 0, 0, DIG_BAD2));
    vecs.push_back(mk(AN_BLANK, SEG_OFF, 1, 0, 1, 1, DIG_BAD2));
    vecs.push_back(mk(AN_BLANK, SEG_OFF, 0, 0, 0, 1, DIG_BAD2));

    // Instance B: glitch 8 on digit 1 for 2 clocks, then 7 for 5 clocks
    bseq.push_back('{an: AN_BLANK, seg: SEG_OFF, n: 2});
    bseq.push_back('{an: AN_D0,    seg: SEG_1,   n: 4});
    bseq.push_back('{an: AN_D1,    seg: SEG_8,   n: 2});
    bseq.push_back('{an: AN_D1,    seg: SEG_7,   n: 5});
    bseq.push_back('{an: AN_D2,    seg: SEG_3,   n: 4});
    bseq.push_back('{an: AN_D3,    seg: SEG_4,   n: 4});
    bseq.push_back('{an: AN_BLANK, seg: SEG_OFF, n: 5});

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check("rst_digits", 32'(dig_a), 32'h0);
    check("rst_fv", 32'(fv_a), 32'h0);
    check("rst_err", 32'(err_a), 32'h0);
    check("rst_gerr", 32'(gerr_a), 32'h0);
    check("rst_stall", 32'(stall_a), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("idle_fv", 32'(fv_a), 32'h0);
    check("idle_err", 32'(err_a), 32'h0);

    // Settle filter on instance B
    fv_cnt = 0; err_cnt = 0; last_b = '0;
    foreach (bseq[k]) begin
      for (int c = 0; c < bseq[k].n; c++) begin
        an_b = bseq[k].an;
        seg_b = bseq[k].seg;
        @(posedge CLK);
        #1;
        if (fv_b) begin fv_cnt++; last_b = dig_b; end
        if (err_b) err_cnt++;
      end
    end
    check("settle_frames", 32'(fv_cnt), 32'd1);
    check("settle_errs", 32'(err_cnt), 32'd0);
    check("settle_digits", 32'(last_b), 32'(DIG_B));
    check("settle_gerr", 32'(gerr_b), 32'h0);

    // Table on instance A
    foreach (vecs[i]) begin
      step_a(vecs[i].an, vecs[i].seg, vecs[i].clr);
      check($sformatf("vec%0d_fv", i), 32'(fv_a), 32'(vecs[i].fv));
      check($sformatf("vec%0d_err", i), 32'(err_a), 32'(vecs[i].err));
      check($sformatf("vec%0d_gerr", i), 32'(gerr_a), 32'(vecs[i].gerr));
      check($sformatf("vec%0d_digits", i), 32'(dig_a), 32'(vecs[i].dig));
    end

    // Asynchronous reset mid-operation clears outputs without a clock edge
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_digits", 32'(dig_a), 32'h0);
    check("midrst_gerr", 32'(gerr_a), 32'h0);
    check("midrst_fv", 32'(fv_a), 32'h0);
    check("midrst_err", 32'(err_a), 32'h0);
    check("midrst_stall", 32'(stall_a), 32'h0);
    @(posedge CLK);
    #1;
    rst_n = 1'b1;

    // First frame after reset needs a full in-order scan
    begin
      logic [3:0] pa[8];
      logic [6:0] ps[8];
      logic       pf[8];
      logic       pe[8];
      pa = '{AN_D2, AN_D3, AN_D0, AN_D1, AN_D2, AN_D3, AN_BLANK, AN_BLANK};
      ps = '{SEG_3, SEG_4, SEG_1, SEG_2, SEG_3, SEG_4, SEG_OFF, SEG_OFF};
      pf = '{0, 0, 0, 0, 0, 0, 1, 0};
      pe = '{0, 1, 1, 0, 0, 0, 0, 0};
      for (int j = 0; j < 8; j++) begin
        step_a(pa[j], ps[j], 1'b0);
        check($sformatf("post_rst%0d_fv", j), 32'(fv_a), 32'(pf[j]));
        check($sformatf("post_rst%0d_err", j), 32'(err_a), 32'(pe[j]));
      end
      check("post_rst_digits", 32'(dig_a), 32'(DIG_1234));
    end

    // Stall: legal capture, then anodes blank for 20+ clocks
    step_a(AN_D0, SEG_1, 1'b0);
    for (int n = 1; n <= 21; n++) begin
      step_a(AN_BLANK, SEG_OFF, 1'b0);
`ifdef SCAN_TIMEOUT_EN
      if (n == 16) check("stall_before", 32'(stall_a), 32'h0);
      if (n == 17) check("stall_at_limit", 32'(stall_a), 32'h1);
      if (n == 21) check("stall_held", 32'(stall_a), 32'h1);
`else
      if (n == 17 || n == 21) check($sformatf("stall_off%0d", n), 32'(stall_a), 32'h0);
`endif
    end
    step_a(AN_D1, SEG_2, 1'b0);
    step_a(AN_BLANK, SEG_OFF, 1'b0);
`ifdef SCAN_TIMEOUT_EN
    check("stall_cleared", 32'(stall_a), 32'h0);
    check("stall_resync_err", 32'(err_a), 32'h1);
`else
    check("nostall_inorder", 32'(err_a), 32'h0);
    check("nostall_level", 32'(stall_a), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
